memory_access: RTL and testbench
================================

# memory_access

Memory stage of the in-order pipeline, directly downstream of `execute`. It consumes one `exec_data_t` per accepted instruction and performs loads and stores over the data bus. It formats store data and strobes, and sign- or zero-extends load data. It emits a registered `mem_data_t` to writeback and stalls upstream while a bus transaction is outstanding.

## Interface
- No parameters. All widths are fixed by `common` and `pipes`: `word_t` is 64 bits, `addr_t` is 64 bits.
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `dataE` holds a valid instruction.
- `in_ready`  out  1  stage can accept `dataE` this cycle.
- `dataE`  in  `exec_data_t`  from execute. Fields used: `ctl.op`, `aluout` (effective address or result), `rd` (store data), `dst`, `instr`, `ctl`.
- `flush`  in  1  kill the instruction held in this stage.
- `out_valid`  out  1  `dataM` is valid for one cycle.
- `dataM`  out  `mem_data_t`  holds `{ctl, dst, instr, result, addr, misalign}`.
- `dreq_valid`  out  1  data-bus request valid.
- `dreq_addr`  out  64  address, 8-byte-aligned low bits kept as `aluout`.
- `dreq_size`  out  3  0=B, 1=H, 2=W, 3=D.
- `dreq_strobe`  out  8  byte-write enables; all zero for a load.
- `dreq_data`  out  64  lane-shifted store data.
- `dresp_data_ok`  in  1  bus has completed the request.
- `dresp_data`  in  64  load data, aligned to the doubleword.

## Operation
- FSM states: IDLE and BUSY.
  - `in_ready` = (state == IDLE).
  - `dataE` is accepted when `in_valid & in_ready & ~flush`.
- Memory ops:
  - Loads: LB, LH, LW, LD, LBU, LHU, LWU.
  - Stores: SB, SH, SW, SD.
  - Every other op is a non-memory op.
- Non-memory op accepted in IDLE:
  - `dataM.result` = `dataE.aluout`.
  - `out_valid` is asserted the next cycle.
  - State stays IDLE.
- Misalignment:
  - Defined as addr[0] set for H, addr[1:0] nonzero for W, addr[2:0] nonzero for D.
  - No bus request is issued.
  - Next cycle `out_valid=1`, `dataM.misalign=1`, `result=0`.
  - State stays IDLE.
- Aligned memory op accepted:
  - Latch the request registers and go to BUSY.
  - `dreq_*` are driven from the registers and held constant until `dresp_data_ok`.
- Store formatting, with off = addr[2:0]:
  - `dreq_data` = `rd << (8*off)`.
  - `dreq_strobe` = (B: 8'h01, H: 8'h03, W: 8'h0F, D: 8'hFF) `<< off`.
- Load formatting:
  - raw = `dresp_data >> (8*off)`, truncated to the access size.
  - LB, LH, LW sign-extend to 64 bits; LBU, LHU, LWU zero-extend; LD is used as-is.
  - The result is registered into `dataM.result`.
- In BUSY with `dresp_data_ok=1`:
  - Register `dataM` and return to IDLE.
  - `out_valid` is asserted the next cycle unless the instruction was killed.
- Flush:
  - In IDLE, `flush` blocks acceptance.
  - In BUSY, `flush` sets an internal `killed` flag. The bus request is NOT withdrawn; the stage waits for `dresp_data_ok`, then returns to IDLE with `out_valid=0`.
  - `killed` clears on entry to IDLE.
- `dataM.addr` = `dataE.aluout` for every accepted instruction. All other `dataM` fields are copied from `dataE`.

## Timing
- Reset (asynchronous assertion, synchronous release). While `reset` is low:
  - State = IDLE, `killed=0`.
  - `out_valid=0`, `dataM='0`.
  - `dreq_valid=0`, `dreq_addr=0`, `dreq_size=0`, `dreq_strobe=0`, `dreq_data=0`.
  - Reset during BUSY abandons the transaction.
- Non-memory or misaligned op accepted at cycle t: `out_valid` at t+1. Throughput is one per cycle.
- Aligned memory op accepted at t:
  - `dreq_valid=1` from t+1.
  - `dresp_data_ok` at cycle k ≥ t+1 gives `dreq_valid=0` and `out_valid=1` at k+1.
  - `in_ready=0` during t+1..k and returns to 1 at k+1.
  - A new instruction may be accepted at k+1.
- `dresp_data_ok` in the same cycle as the first `dreq_valid` is legal and gives a 2-cycle total latency.
- `dresp_data_ok` while IDLE is ignored.
- `flush` and `dresp_data_ok` in the same cycle: the instruction is killed and `out_valid` stays 0 at k+1.
- `out_valid` is a single-cycle pulse per instruction; `dataM` holds its value otherwise.

## Test plan
- Reset mid-BUSY:
  - Stimulus: issue LD to 0x1000, then pull `reset` low before `data_ok`.
  - Required: all outputs go to 0 immediately, and `in_ready=1` after release.
- SB with store data 0xAB, addr 0x2005:
  - Required: `dreq_addr=0x2005`, `dreq_size=0`, `dreq_strobe=8'h20`, `dreq_data=0x0000_AB00_0000_0000`.
  - Required: `dreq_valid` is held for 3 cycles with `data_ok` delayed, and `out_valid` comes 1 cycle after `data_ok`.
- Loads to addr 0x3004 with `dresp_data=0x8000_0001_0000_0000`:
  - LW → result 0xFFFF_FFFF_8000_0001.
  - LWU → 0x0000_0000_8000_0001.
  - LH → 0x0000_0000_0000_0001.
- Misaligned LW at 0x3002:
  - Required: no `dreq_valid`, `out_valid` at t+1 with `misalign=1`.
- Back-to-back stream ADD (aluout 5), SD to 0x4000, ADD (aluout 7), with `data_ok` 2 cycles after the request:
  - Required: `out_valid` pulses at t+1, t+4, t+5 with results 5, store, 7.
  - Required: `in_ready` is low exactly while BUSY.
- Flush during BUSY:
  - Stimulus: LD outstanding, `flush=1` for one cycle, `data_ok` 2 cycles later.
  - Required: `dreq_valid` is held until `data_ok`, no `out_valid` follows, and the next ADD is accepted normally.

Source files
------------

// File: rtl/memory_access.sv
// Memory stage: formats stores, issues one data-bus request at a time, extends loads.
// dataE = {ctl[7:0], dst[4:0], instr[31:0], aluout[63:0], rd[63:0]}, op = ctl[4:0];
// dataM = {ctl[7:0], dst[4:0], instr[31:0], result[63:0], addr[63:0], misalign}.
module memory_access (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [172:0] dataE,
  input  logic         flush,
  output logic         out_valid,
  output logic [173:0] dataM,
  output logic         dreq_valid,
  output logic [63:0]  dreq_addr,
  output logic [2:0]   dreq_size,
  output logic [7:0]   dreq_strobe,
  output logic [63:0]  dreq_data,
  input  logic         dresp_data_ok,
  input  logic [63:0]  dresp_data
);

  localparam logic [4:0] OP_LB  = 5'd1;
  localparam logic [4:0] OP_LH  = 5'd2;
  localparam logic [4:0] OP_LW  = 5'd3;
  localparam logic [4:0] OP_LD  = 5'd4;
  localparam logic [4:0] OP_LBU = 5'd5;
  localparam logic [4:0] OP_LHU = 5'd6;
  localparam logic [4:0] OP_LWU = 5'd7;
  localparam logic [4:0] OP_SB  = 5'd8;
  localparam logic [4:0] OP_SH  = 5'd9;
  localparam logic [4:0] OP_SW  = 5'd10;
  localparam logic [4:0] OP_SD  = 5'd11;

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t state, state_next;

  logic [7:0]  e_ctl;
  logic [4:0]  e_dst;
  logic [31:0] e_instr;
  logic [63:0] e_aluout;
  logic [63:0] e_rd;
  logic [4:0]  e_op;
  logic [2:0]  e_off;

  assign e_ctl    = dataE[172:165];
  assign e_dst    = dataE[164:160];
  assign e_instr  = dataE[159:128];
  assign e_aluout = dataE[127:64];
  assign e_rd     = dataE[63:0];
  assign e_op     = e_ctl[4:0];
  assign e_off    = e_aluout[2:0];

  logic       e_load;
  logic       e_store;
  logic       e_signed;
  logic [1:0] e_size;
  logic       e_misalign;

  always_comb begin
    e_load   = 1'b0;
    e_store  = 1'b0;
    e_signed = 1'b0;
    e_size   = 2'd0;
    case (e_op)
      OP_LB:   begin e_load = 1'b1;  e_signed = 1'b1; e_size = 2'd0; end
      OP_LH:   begin e_load = 1'b1;  e_signed = 1'b1; e_size = 2'd1; end
      OP_LW:   begin e_load = 1'b1;  e_signed = 1'b1; e_size = 2'd2; end
      OP_LD:   begin e_load = 1'b1;  e_size = 2'd3; end
      OP_LBU:  begin e_load = 1'b1;  e_size = 2'd0; end
      OP_LHU:  begin e_load = 1'b1;  e_size = 2'd1; end
      OP_LWU:  begin e_load = 1'b1;  e_size = 2'd2; end
      OP_SB:   begin e_store = 1'b1; e_size = 2'd0; end
      OP_SH:   begin e_store = 1'b1; e_size = 2'd1; end
      OP_SW:   begin e_store = 1'b1; e_size = 2'd2; end
      OP_SD:   begin e_store = 1'b1; e_size = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    e_misalign = 1'b0;
    if (e_load || e_store) begin
      case (e_size)
        2'd1:    e_misalign = e_aluout[0];
        2'd2:    e_misalign = |e_aluout[1:0];
        2'd3:    e_misalign = |e_aluout[2:0];
        default: e_misalign = 1'b0;
      endcase
    end
  end

  logic [7:0]  st_base;
  logic [7:0]  st_strobe;
  logic [63:0] st_data;

  always_comb begin
    case (e_size)
      2'd0:    st_base = 8'h01;
      2'd1:    st_base = 8'h03;
      2'd2:    st_base = 8'h0F;
      default: st_base = 8'hFF;
    endcase
  end

  assign st_strobe = st_base << e_off;
  assign st_data   = e_rd << {e_off, 3'b000};

  // Fields of the in-flight instruction, kept apart from dataM so dataM stays stable while BUSY.
  logic [7:0]  hold_ctl;
  logic [4:0]  hold_dst;
  logic [31:0] hold_instr;
  logic        hold_load;
  logic        hold_signed;
  logic        killed;

  logic [63:0] ld_shift;
  logic [63:0] ld_result;

  assign ld_shift = dresp_data >> {dreq_addr[2:0], 3'b000};

  always_comb begin
    case (dreq_size[1:0])
      2'd0:    ld_result = {{56{hold_signed & ld_shift[7]}},  ld_shift[7:0]};
      2'd1:    ld_result = {{48{hold_signed & ld_shift[15]}}, ld_shift[15:0]};
      2'd2:    ld_result = {{32{hold_signed & ld_shift[31]}}, ld_shift[31:0]};
      default: ld_result = ld_shift;
    endcase
  end

  logic accept;
  logic issue;
  logic finish;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          accept = 1'b1;
          if ((e_load || e_store) && !e_misalign) begin
            issue      = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (dresp_data_ok) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      dataM       <= '0;
      dreq_valid  <= 1'b0;
      dreq_addr   <= '0;
      dreq_size   <= '0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
      hold_ctl    <= '0;
      hold_dst    <= '0;
      hold_instr  <= '0;
      hold_load   <= 1'b0;
      hold_signed <= 1'b0;
      killed      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !issue) begin
        out_valid <= 1'b1;
        dataM     <= {e_ctl, e_dst, e_instr, (e_misalign ? 64'd0 : e_aluout),
                      e_aluout, e_misalign};
      end
      if (issue) begin
        dreq_valid  <= 1'b1;
        dreq_addr   <= e_aluout;
        dreq_size   <= {1'b0, e_size};
        dreq_strobe <= e_store ? st_strobe : 8'h00;
        dreq_data   <= e_store ? st_data : 64'd0;
        hold_ctl    <= e_ctl;
        hold_dst    <= e_dst;
        hold_instr  <= e_instr;
        hold_load   <= e_load;
        hold_signed <= e_signed;
      end
      // A flush arriving with the response still kills the instruction.
      if (finish) begin
        dreq_valid <= 1'b0;
        out_valid  <= !(killed || flush);
        dataM      <= {hold_ctl, hold_dst, hold_instr, (hold_load ? ld_result : 64'd0),
                       dreq_addr, 1'b0};
        killed     <= 1'b0;
      end else if (state == BUSY && flush) begin
        killed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: reset, store formatting, load extension,
// misalignment, back-to-back stream and flush handling.
module tb_memory_access;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_LB  = 5'd1;
  localparam logic [4:0] OP_LH  = 5'd2;
  localparam logic [4:0] OP_LW  = 5'd3;
  localparam logic [4:0] OP_LD  = 5'd4;
  localparam logic [4:0] OP_LBU = 5'd5;
  localparam logic [4:0] OP_LWU = 5'd7;
  localparam logic [4:0] OP_SB  = 5'd8;
  localparam logic [4:0] OP_SD  = 5'd11;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [172:0] dataE;
  logic         flush;
  logic         out_valid;
  logic [173:0] dataM;
  logic         dreq_valid;
  logic [63:0]  dreq_addr;
  logic [2:0]   dreq_size;
  logic [7:0]   dreq_strobe;
  logic [63:0]  dreq_data;
  logic         dresp_data_ok;
  logic [63:0]  dresp_data;

  int n_cmp = 0;
  int n_err = 0;

  memory_access dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dataE(dataE), .flush(flush), .out_valid(out_valid), .dataM(dataM),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [172:0] pk(input logic [4:0] op, input logic [63:0] alu,
                                      input logic [63:0] rd);
    return {3'b000, op, 5'd3, 32'h0000_0013, alu, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] m_result();
    return dataM[128:65];
  endfunction

  function automatic logic [63:0] m_addr();
    return dataM[64:1];
  endfunction

  // Load accepted at t, response in the first request cycle, result checked at t+2.
  task automatic do_load(input string tag, input logic [4:0] op, input logic [63:0] addr,
                         input logic [63:0] resp, input logic [63:0] exp);
    dataE = pk(op, addr, 64'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_req"}, dreq_valid, 1'b1);
    chk({tag, "_strb"}, dreq_strobe, 8'h00);
    dresp_data = resp;
    dresp_data_ok = 1'b1;
    tick();
    dresp_data_ok = 1'b0;
    chk({tag, "_ov"}, out_valid, 1'b1);
    chk({tag, "_res"}, m_result(), exp);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    dataE = '0;
    flush = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data = '0;
    #12;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_dreq", dreq_valid, 1'b0);
    reset = 1'b1;
    tick();

    // Reset mid-BUSY
    dataE = pk(OP_LD, 64'h1000, 64'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ld_req", dreq_valid, 1'b1);
    chk("ld_addr", dreq_addr, 64'h1000);
    chk("ld_size", dreq_size, 3'd3);
    chk("ld_busy", in_ready, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("mrst_dreq", dreq_valid, 1'b0);
    chk("mrst_addr", dreq_addr, 64'h0);
    chk("mrst_size", dreq_size, 3'd0);
    chk("mrst_ov", out_valid, 1'b0);
    chk("mrst_dataM", {63'd0, |dataM}, 64'd0);
    #1 reset = 1'b1;
    tick();
    chk("mrst_ready", in_ready, 1'b1);
    chk("mrst_req_after", dreq_valid, 1'b0);

    // SB 0xAB at 0x2005, data_ok delayed to the third request cycle
    dataE = pk(OP_SB, 64'h2005, 64'hAB);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sb_addr", dreq_addr, 64'h2005);
    chk("sb_size", dreq_size, 3'd0);
    chk("sb_strb", dreq_strobe, 8'h20);
    chk("sb_data", dreq_data, 64'h0000_AB00_0000_0000);
    for (int i = 0; i < 3; i++) begin
      chk("sb_hold", dreq_valid, 1'b1);
      chk("sb_noov", out_valid, 1'b0);
      chk("sb_strb_hold", dreq_strobe, 8'h20);
      if (i == 2) dresp_data_ok = 1'b1;
      tick();
    end
    dresp_data_ok = 1'b0;
    chk("sb_done_req", dreq_valid, 1'b0);
    chk("sb_ov", out_valid, 1'b1);
    chk("sb_maddr", m_addr(), 64'h2005);
    chk("sb_ready", in_ready, 1'b1);
    tick();
    chk("sb_pulse", out_valid, 1'b0);

    // Loads around 0x3000
    do_load("lw",  OP_LW,  64'h3004, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);
    do_load("lwu", OP_LWU, 64'h3004, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001);
    do_load("lh",  OP_LH,  64'h3004, 64'h8000_0001_0000_0000, 64'h0000_0000_0000_0001);
    do_load("lb",  OP_LB,  64'h3007, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("lbu", OP_LBU, 64'h3007, 64'h8000_0001_0000_0000, 64'h0000_0000_0000_0080);
    do_load("ld",  OP_LD,  64'h3000, 64'h8000_0001_0000_0000, 64'h8000_0001_0000_0000);

    // Misaligned LW
    dataE = pk(OP_LW, 64'h3002, 64'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mis_req", dreq_valid, 1'b0);
    chk("mis_ov", out_valid, 1'b1);
    chk("mis_flag", dataM[0], 1'b1);
    chk("mis_res", m_result(), 64'h0);
    chk("mis_ready", in_ready, 1'b1);
    tick();

    // data_ok while idle is ignored
    dresp_data_ok = 1'b1;
    tick();
    dresp_data_ok = 1'b0;
    chk("idle_ok_ov", out_valid, 1'b0);
    chk("idle_ok_req", dreq_valid, 1'b0);

    // ADD 5, SD 0x4000, ADD 7
    dataE = pk(OP_ADD, 64'd5, 64'h0);
    in_valid = 1'b1;
    tick();
    chk("s1_ov", out_valid, 1'b1);
    chk("s1_res", m_result(), 64'd5);
    chk("s1_dst", dataM[165:161], 5'd3);
    dataE = pk(OP_SD, 64'h4000, 64'h1122_3344_5566_7788);
    tick();
    chk("s2_ov", out_valid, 1'b0);
    chk("s2_req", dreq_valid, 1'b1);
    chk("s2_strb", dreq_strobe, 8'hFF);
    chk("s2_busy", in_ready, 1'b0);
    dataE = pk(OP_ADD, 64'd7, 64'h0);
    tick();
    chk("s3_busy", in_ready, 1'b0);
    chk("s3_ov", out_valid, 1'b0);
    dresp_data_ok = 1'b1;
    tick();
    dresp_data_ok = 1'b0;
    chk("s4_ov", out_valid, 1'b1);
    chk("s4_maddr", m_addr(), 64'h4000);
    chk("s4_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("s5_ov", out_valid, 1'b1);
    chk("s5_res", m_result(), 64'd7);
    tick();
    chk("s6_ov", out_valid, 1'b0);

    // Flush during BUSY
    dataE = pk(OP_LD, 64'h1000, 64'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_hold1", dreq_valid, 1'b1);
    tick();
    chk("fl_hold2", dreq_valid, 1'b1);
    dresp_data = 64'h1234;
    dresp_data_ok = 1'b1;
    tick();
    dresp_data_ok = 1'b0;
    chk("fl_req_drop", dreq_valid, 1'b0);
    chk("fl_no_ov", out_valid, 1'b0);
    chk("fl_ready", in_ready, 1'b1);
    dataE = pk(OP_ADD, 64'd9, 64'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("fl_next_ov", out_valid, 1'b1);
    chk("fl_next_res", m_result(), 64'd9);

    // Flush coinciding with data_ok
    dataE = pk(OP_LD, 64'h1008, 64'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    dresp_data_ok = 1'b1;
    tick();
    flush = 1'b0;
    dresp_data_ok = 1'b0;
    chk("flok_ov", out_valid, 1'b0);
    chk("flok_ready", in_ready, 1'b1);

    // Flush in IDLE blocks acceptance
    dataE = pk(OP_ADD, 64'd11, 64'h0);
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("idle_fl_ov", out_valid, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
